nn_layer_scheduler: RTL and testbench

Sequencer for the shared CORDIC MAC/activation datapath in layer-by-layer NN inference. On `start` it captures the network configuration:
- layer count
- neurons per layer
- activation function per layer

It then walks every layer, neuron and fan-in input. For each step it issues MAC beats with weight and activation addresses, requests the activation, and writes the neuron result into a ping-pong activation buffer. It sits between the top-level config inputs and the MAC/activation/buffer datapath.

---
 rtl/nn_sched_pkg.sv | 28 ++
 rtl/nn_sched_if.sv | 34 +++
 rtl/nn_layer_scheduler_addr_gen.sv | 40 ++++
 rtl/nn_layer_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_nn_layer_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_sched_pkg.sv
// nn_layer_scheduler shared types and constants.
// Optional bias beat per neuron is enabled with the NN_BIAS_EN macro.
package nn_sched_pkg;

  localparam int MAX_LAYERS = 5;
  localparam int NW_DEF     = 6;
  localparam int AW_DEF     = 15;
  localparam int LIX_W      = 3;

  localparam logic [NW_DEF-1:0] BIAS_X = '1;

  localparam logic [1:0] ACT_LIN  = 2'b00;
  localparam logic [1:0] ACT_SIG  = 2'b01;
  localparam logic [1:0] ACT_TANH = 2'b10;
  localparam logic [1:0] ACT_RELU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_N_INIT,
    S_MAC,
    S_ACT,
    S_WR,
    S_NEXT,
    S_FIN
  } state_t;

endpackage

// File: rtl/nn_sched_if.sv
// Scheduler <-> MAC/activation/buffer datapath bundle.
// Build option NN_BIAS_EN only changes the beat pattern, not this bundle.
interface nn_sched_if
  import nn_sched_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int AW = AW_DEF
);

  logic          mac_clr;
  logic          mac_vld;
  logic          mac_rdy;
  logic [AW-1:0] w_addr;
  logic [NW-1:0] x_addr;
  logic          x_bank;
  logic          act_req;
  logic [1:0]    act_fn;
  logic          act_ack;
  logic          y_we;
  logic [NW-1:0] y_addr;

  modport master (
    output mac_clr, mac_vld, w_addr, x_addr, x_bank,
    output act_req, act_fn, y_we, y_addr,
    input  mac_rdy, act_ack
  );

  modport slave (
    input  mac_clr, mac_vld, w_addr, x_addr, x_bank,
    input  act_req, act_fn, y_we, y_addr,
    output mac_rdy, act_ack
  );

endinterface

// File: rtl/nn_layer_scheduler_addr_gen.sv
// Weight address and bank generator for nn_layer_scheduler.
// Stride (with or without NN_BIAS_EN bias slot) is supplied by the FSM.
module nn_addr_gen
  import nn_sched_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          nxt_neuron,
  input  logic          nxt_layer,
  input  logic [AW-1:0] stride,
  input  logic [NW-1:0] idx,
  output logic [AW-1:0] w_addr,
  output logic          x_bank
);

  logic [AW-1:0] base_q;
  logic [AW-1:0] ofs_q;

  // ofs_q walks j*stride by repeated add, so no multiplier is needed
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      base_q <= '0;
      ofs_q  <= '0;
      x_bank <= 1'b0;
    end else if (nxt_neuron) begin
      ofs_q <= ofs_q + stride;
    end else if (nxt_layer) begin
      base_q <= base_q + ofs_q + stride;
      ofs_q  <= '0;
      x_bank <= ~x_bank;
    end
  end

  assign w_addr = base_q + ofs_q + AW'(idx);

endmodule

// File: rtl/nn_layer_scheduler.sv
// Layer/neuron/fan-in sequencer for the shared MAC/activation datapath.
// Define NN_BIAS_EN to add one bias beat (x_addr all-ones) per neuron.
module nn_layer_scheduler
  import nn_sched_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] no_layers,
  input  logic [NW-1:0] n_in,
  input  logic [NW-1:0] nl1,
  input  logic [NW-1:0] nl2,
  input  logic [NW-1:0] nl3,
  input  logic [NW-1:0] nl4,
  input  logic [NW-1:0] nl5,
  input  logic [1:0]    afl1,
  input  logic [1:0]    afl2,
  input  logic [1:0]    afl3,
  input  logic [1:0]    afl4,
  input  logic [1:0]    afl5,
  nn_sched_if.master    dp,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int LD = 1 << LIX_W;

  state_t state_q, state_d;

  logic [NW-1:0]    no_layers_q;
  logic [NW-1:0]    n_in_q;
  logic [NW-1:0]    nl_q  [LD];
  logic [1:0]       afl_q [LD];
  logic [NW-1:0]    l_q;
  logic [NW-1:0]    j_q;
  logic [NW-1:0]    i_q;
  logic [LIX_W-1:0] lix;
  logic [NW-1:0]    fan_in;
  logic [NW-1:0]    nl_cur;
  logic [NW-1:0]    last_idx;
  logic [AW-1:0]    stride;
  logic             cfg_bad;
  logic             beat_ok;
  logic             bias_beat;
  logic             last_beat;
  logic             last_neuron;
  logic             last_layer;

  assign lix    = l_q[LIX_W-1:0];
  assign fan_in = (l_q == '0) ? n_in_q
                              : nl_q[lix - LIX_W'(1)];
  assign nl_cur = nl_q[lix];

`ifdef NN_BIAS_EN
  assign last_idx  = fan_in;
  assign stride    = AW'(fan_in) + AW'(1);
  assign bias_beat = (state_q == S_MAC) && (i_q == fan_in);
`else
  assign last_idx  = fan_in - NW'(1);
  assign stride    = AW'(fan_in);
  assign bias_beat = 1'b0;
`endif

  assign beat_ok     = (state_q == S_MAC) && dp.mac_rdy;
  assign last_beat   = (i_q == last_idx);
  assign last_neuron = (j_q == nl_cur - NW'(1));
  assign last_layer  = (l_q + NW'(1) == no_layers_q);

  always_comb begin
    cfg_bad = (no_layers_q == '0)
           || (no_layers_q > NW'(MAX_LAYERS))
           || (n_in_q == '0);
    for (int k = 0; k < MAX_LAYERS; k++) begin
      if ((NW'(k) < no_layers_q) && (nl_q[k] == '0)) begin
        cfg_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      no_layers_q <= '0;
      n_in_q      <= '0;
      l_q         <= '0;
      j_q         <= '0;
      i_q         <= '0;
      err         <= 1'b0;
      for (int k = 0; k < LD; k++) begin
        nl_q[k]  <= '0;
        afl_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      err     <= (state_q == S_CHECK) && cfg_bad;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            no_layers_q <= no_layers;
            n_in_q      <= n_in;
            nl_q[0]     <= nl1;
            nl_q[1]     <= nl2;
            nl_q[2]     <= nl3;
            nl_q[3]     <= nl4;
            nl_q[4]     <= nl5;
            afl_q[0]    <= afl1;
            afl_q[1]    <= afl2;
            afl_q[2]    <= afl3;
            afl_q[3]    <= afl4;
            afl_q[4]    <= afl5;
          end
        end
        S_CHECK: begin
          l_q <= '0;
          j_q <= '0;
          i_q <= '0;
        end
        S_N_INIT: i_q <= '0;
        S_MAC: begin
          if (beat_ok) i_q <= i_q + NW'(1);
        end
        S_NEXT: begin
          if (last_neuron) begin
            j_q <= '0;
            l_q <= l_q + NW'(1);
          end else begin
            j_q <= j_q + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    dp.mac_clr = 1'b0;
    dp.mac_vld = 1'b0;
    dp.act_req = 1'b0;
    dp.y_we    = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_CHECK;
      S_CHECK:  state_d = cfg_bad ? S_IDLE : S_N_INIT;
      S_N_INIT: begin
        dp.mac_clr = 1'b1;
        state_d    = S_MAC;
      end
      S_MAC: begin
        dp.mac_vld = 1'b1;
        if (beat_ok && last_beat) state_d = S_ACT;
      end
      S_ACT: begin
        dp.act_req = 1'b1;
        if (dp.act_ack) state_d = S_WR;
      end
      S_WR: begin
        dp.y_we = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        state_d = (last_neuron && last_layer) ? S_FIN : S_N_INIT;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign dp.x_addr = bias_beat ? BIAS_X : i_q;
  assign dp.y_addr = j_q;
  assign dp.act_fn = afl_q[lix];

  nn_addr_gen #(
    .NW(NW),
    .AW(AW)
  ) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state_q == S_CHECK),
    .nxt_neuron (state_q == S_NEXT && !last_neuron),
    .nxt_layer  (state_q == S_NEXT && last_neuron),
    .stride     (stride),
    .idx        (i_q),
    .w_addr     (dp.w_addr),
    .x_bank     (dp.x_bank)
  );

endmodule

// File: tb/tb_nn_layer_scheduler.sv
// Directed bench for nn_layer_scheduler.
// Build with NN_BIAS_EN to expect the bias-beat pattern.
module tb_nn_layer_scheduler;
  import nn_sched_pkg::*;

  localparam int NW = 6;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [NW-1:0] no_layers = '0, n_in = '0;
  logic [NW-1:0] nl1 = '0, nl2 = '0, nl3 = '0, nl4 = '0, nl5 = '0;
  logic [1:0] afl1 = 2'd1, afl2 = 2'd2, afl3 = 2'd3;
  logic [1:0] afl4 = 2'd0, afl5 = 2'd0;
  logic busy, done, err;
  logic stall_en = 1'b0;

  nn_sched_if #(.NW(NW), .AW(AW)) dp ();

  nn_layer_scheduler #(.NW(NW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .no_layers(no_layers), .n_in(n_in),
    .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
    .afl1(afl1), .afl2(afl2), .afl3(afl3), .afl4(afl4), .afl5(afl5),
    .dp(dp), .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

`ifdef NN_BIAS_EN
  localparam int NB = 23;
  int xexp [NB] = '{0,1,63, 0,1,63,
                    0,1,63, 0,1,63, 0,1,63,
                    0,1,2,63, 0,1,2,63};
`else
  localparam int NB = 16;
  int xexp [NB] = '{0,1, 0,1,
                    0,1, 0,1, 0,1,
                    0,1,2, 0,1,2};
`endif
  int yexp [7] = '{0,1, 0,1,2, 0,1};
  int bexp [7] = '{0,0, 1,1,1, 0,0};
  int fexp [7] = '{1,1, 2,2,2, 3,3};

  int nb = 0, ny = 0, ndone = 0, nerr = 0, nclr = 0;
  int nvld = 0, nstall = 0, hold_bad = 0;
  int wlog [512];
  int xlog [512];
  int ylog [128];
  int blog [128];
  int flog [128];
  bit stall_pend = 0;
  int hw = 0, hx = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 dp.mac_rdy = stall_en ? ~dp.mac_rdy : 1'b1;
  end

  always @(posedge clk) begin
    if (!rst_n) dp.act_ack <= 1'b0;
    else dp.act_ack <= dp.act_req && !dp.act_ack;
  end

  always @(negedge clk) begin
    if (stall_pend) begin
      if (!dp.mac_vld || int'(dp.w_addr) != hw || int'(dp.x_addr) != hx)
        hold_bad++;
    end
    stall_pend = dp.mac_vld && !dp.mac_rdy;
    hw = int'(dp.w_addr);
    hx = int'(dp.x_addr);
    if (dp.mac_vld) nvld++;
    if (dp.mac_vld && !dp.mac_rdy) nstall++;
    if (dp.mac_vld && dp.mac_rdy) begin
      if (nb < 512) begin
        wlog[nb] = int'(dp.w_addr);
        xlog[nb] = int'(dp.x_addr);
      end
      nb++;
    end
    if (dp.y_we) begin
      if (ny < 128) begin
        ylog[ny] = int'(dp.y_addr);
        blog[ny] = int'(dp.x_bank);
        flog[ny] = int'(dp.act_fn);
      end
      ny++;
    end
    if (dp.mac_clr) nclr++;
    if (done) ndone++;
    if (err) nerr++;
  end

  task automatic start_cfg(input int nlay, input int ni,
                           input int a, input int b, input int c);
    @(negedge clk);
    no_layers = NW'(nlay);
    n_in = NW'(ni);
    nl1 = NW'(a);
    nl2 = NW'(b);
    nl3 = NW'(c);
    nl4 = '0;
    nl5 = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output bit to);
    int n;
    n = 0;
    to = 0;
    while (!(done || err) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) to = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {dp.mac_clr, dp.mac_vld, dp.act_req, dp.y_we,
           dp.x_bank, busy, done, err};
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl got %b want 00000000", obs);
    end
    checks++;
    if (dp.w_addr !== '0 || dp.x_addr !== '0 || dp.y_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr got w=%0d x=%0d y=%0d want 0",
               dp.w_addr, dp.x_addr, dp.y_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int b0, y0, d0, c0, e0;
    bit to;
    b0 = nb; y0 = ny; d0 = ndone; c0 = nclr; e0 = nerr;
    start_cfg(3, 2, 2, 3, 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b want 1", busy);
    end
    wait_end(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout got timeout want done");
    end
    checks++;
    if (nb - b0 != NB) begin
      errors++;
      $display("FAIL basic_beats got %0d want %0d", nb - b0, NB);
    end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (wlog[b0+k] != k || xlog[b0+k] != xexp[k]) begin
        errors++;
        $display("FAIL basic_beat%0d got w=%0d x=%0d want w=%0d x=%0d",
                 k, wlog[b0+k], xlog[b0+k], k, xexp[k]);
      end
    end
    checks++;
    if (ny - y0 != 7) begin
      errors++;
      $display("FAIL basic_writes got %0d want 7", ny - y0);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (ylog[y0+k] != yexp[k] || blog[y0+k] != bexp[k] ||
          flog[y0+k] != fexp[k]) begin
        errors++;
        $display("FAIL basic_wr%0d got y=%0d bank=%0d fn=%0d want y=%0d bank=%0d fn=%0d",
                 k, ylog[y0+k], blog[y0+k], flog[y0+k],
                 yexp[k], bexp[k], fexp[k]);
      end
    end
    checks++;
    if (ndone - d0 != 1 || nclr - c0 != 7 || nerr - e0 != 0) begin
      errors++;
      $display("FAIL basic_pulses got done=%0d clr=%0d err=%0d want 1 7 0",
               ndone - d0, nclr - c0, nerr - e0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_stall();
    int b0, d0, h0, s0;
    bit to;
    b0 = nb; d0 = ndone; h0 = hold_bad; s0 = nstall;
    stall_en = 1'b1;
    start_cfg(3, 2, 2, 3, 2);
    wait_end(to);
    stall_en = 1'b0;
    checks++;
    if (to || nb - b0 != NB) begin
      errors++;
      $display("FAIL stall_beats got %0d to=%0d want %0d", nb - b0, to, NB);
    end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (wlog[b0+k] != k || xlog[b0+k] != xexp[k]) begin
        errors++;
        $display("FAIL stall_beat%0d got w=%0d x=%0d want w=%0d x=%0d",
                 k, wlog[b0+k], xlog[b0+k], k, xexp[k]);
      end
    end
    checks++;
    if (hold_bad - h0 != 0 || nstall - s0 == 0) begin
      errors++;
      $display("FAIL stall_hold got bad=%0d stalls=%0d want 0 and >0",
               hold_bad - h0, nstall - s0);
    end
    checks++;
    if (ndone - d0 != 1) begin
      errors++;
      $display("FAIL stall_done got %0d want 1", ndone - d0);
    end
  endtask

  task automatic test_bad_cfg();
    int cfg [3][5] = '{'{0, 2, 2, 3, 2},
                       '{6, 2, 2, 3, 2},
                       '{3, 2, 2, 0, 2}};
    int v0, y0, e0, c0, d0;
    for (int t = 0; t < 3; t++) begin
      v0 = nvld; y0 = ny; e0 = nerr; c0 = nclr; d0 = ndone;
      start_cfg(cfg[t][0], cfg[t][1], cfg[t][2], cfg[t][3], cfg[t][4]);
      checks++;
      if (busy !== 1'b1 || err !== 1'b0) begin
        errors++;
        $display("FAIL bad%0d_check got busy=%b err=%b want 1 0", t, busy, err);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad%0d_err got err=%b busy=%b want 1 0", t, err, busy);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (nerr - e0 != 1 || nvld - v0 != 0 || ny - y0 != 0 ||
          nclr - c0 != 0 || ndone - d0 != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad%0d_quiet got err=%0d vld=%0d we=%0d clr=%0d done=%0d busy=%b want 1 0 0 0 0 0",
                 t, nerr - e0, nvld - v0, ny - y0, nclr - c0,
                 ndone - d0, busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    int y0, n, b1, d1;
    logic [7:0] obs;
    bit to;
    y0 = ny;
    start_cfg(3, 2, 2, 3, 2);
    n = 0;
    while (!((ny - y0) >= 2 && dp.mac_vld) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000 || dp.x_bank !== 1'b1 || dp.act_fn !== 2'd2) begin
      errors++;
      $display("FAIL mreset_reach got n=%0d bank=%b fn=%0d want layer2 mac",
               n, dp.x_bank, dp.act_fn);
    end
    rst_n = 1'b0;
    @(negedge clk);
    obs = {dp.mac_clr, dp.mac_vld, dp.act_req, dp.y_we,
           dp.x_bank, busy, done, err};
    checks++;
    if (obs !== 8'h00 || dp.w_addr !== '0 || dp.x_addr !== '0 ||
        dp.y_addr !== '0 || dp.act_fn !== 2'd0) begin
      errors++;
      $display("FAIL mreset_zero got ctl=%b w=%0d x=%0d y=%0d fn=%0d want 0",
               obs, dp.w_addr, dp.x_addr, dp.y_addr, dp.act_fn);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (ny - y0 != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mreset_stop got writes=%0d busy=%b want 2 0",
               ny - y0, busy);
    end
    b1 = nb; d1 = ndone;
    start_cfg(3, 2, 2, 3, 2);
    wait_end(to);
    checks++;
    if (to || nb - b1 != NB || wlog[b1] != 0 ||
        wlog[b1+NB-1] != NB - 1 || ndone - d1 != 1) begin
      errors++;
      $display("FAIL mreset_replay got beats=%0d first=%0d last=%0d done=%0d want %0d 0 %0d 1",
               nb - b1, wlog[b1], wlog[b1+NB-1], ndone - d1, NB, NB - 1);
    end
  endtask

  task automatic test_start_busy();
    int b0, d0;
    bit to;
    b0 = nb; d0 = ndone;
    start_cfg(3, 2, 2, 3, 2);
    repeat (6) @(negedge clk);
    no_layers = NW'(1);
    nl1 = NW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(to);
    repeat (6) @(negedge clk);
    checks++;
    if (to || nb - b0 != NB || wlog[b0+NB-1] != NB - 1) begin
      errors++;
      $display("FAIL sbusy_beats got %0d last=%0d want %0d %0d",
               nb - b0, wlog[b0+NB-1], NB, NB - 1);
    end
    checks++;
    if (ndone - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sbusy_done got done=%0d busy=%b want 1 0",
               ndone - d0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bad_cfg();
    test_mid_reset();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
